// File: rtl/alu_serial_exec_pkg.sv
// rtl/alu_serial_exec_pkg.sv - ALU control/shift encodings and execute FSM states
package alu_serial_exec_pkg;

  localparam logic [2:0] ALU_CTL_ADD      = 3'd0;
  localparam logic [2:0] ALU_CTL_SUB      = 3'd1;
  localparam logic [2:0] ALU_CTL_LESS_SIG = 3'd2;
  localparam logic [2:0] ALU_CTL_LESS_UNS = 3'd3;
  localparam logic [2:0] ALU_CTL_OR       = 3'd4;
  localparam logic [2:0] ALU_CTL_AND      = 3'd5;
  localparam logic [2:0] ALU_CTL_XOR      = 3'd6;
  localparam logic [2:0] ALU_CTL_SHIFT    = 3'd7;

  localparam logic [1:0] ALU_SHIFT_NONE = 2'b00;
  localparam logic [1:0] ALU_SHIFT_SLL  = 2'b01;
  localparam logic [1:0] ALU_SHIFT_SRL  = 2'b10;
  localparam logic [1:0] ALU_SHIFT_SRA  = 2'b11;

  localparam logic [0:0] ALU_EXEC_ST_IDLE  = 1'b0;
  localparam logic [0:0] ALU_EXEC_ST_SHIFT = 1'b1;

endpackage

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - combinational single-step shifter feeding the shift work register
module alu_shift_step
  import alu_serial_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] value,
  input  logic [4:0]      amount,
  input  logic [1:0]      mode,
  output logic [XLEN-1:0] shifted
);

  always_comb begin
    shifted = value;
    case (mode)
      ALU_SHIFT_SLL:  shifted = value << amount;
      ALU_SHIFT_SRL:  shifted = value >> amount;
      ALU_SHIFT_SRA:  shifted = $signed(value) >>> amount;
      ALU_SHIFT_NONE: shifted = value;
      default:        shifted = value;
    endcase
  end

endmodule

// File: rtl/alu_serial_exec.sv
// rtl/alu_serial_exec.sv - execute-stage ALU with one-cycle logic/arith ops and iterative shifts
module alu_serial_exec
  import alu_serial_exec_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic [2:0]      i_alu_ctl,
  input  logic [1:0]      i_alu_shift,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  localparam logic [4:0] STEP_AMT = 5'(SHIFT_STEP);

  logic [0:0]      state;
  logic [4:0]      rem;
  logic [XLEN-1:0] work;
  logic [1:0]      mode_q;

  logic [4:0]      shamt;
  logic            accept;
  logic            is_shift_op;
  logic            long_shift;

  logic [XLEN-1:0] step_val;
  logic [4:0]      step_src;
  logic [4:0]      step_amt;
  logic [1:0]      step_mode;
  logic [XLEN-1:0] step_out;
  logic [XLEN-1:0] func_result;

  assign o_ready     = (state == ALU_EXEC_ST_IDLE);
  assign shamt       = i_op_b[4:0];
  assign accept      = i_valid && o_ready && !i_flush;
  assign is_shift_op = (i_alu_ctl == ALU_CTL_SHIFT) && (i_alu_shift != ALU_SHIFT_NONE);
  assign long_shift  = is_shift_op && (shamt > STEP_AMT);

  // The single shifter serves both the first step (from operands) and later steps (from work).
  always_comb begin
    step_val  = i_op_a;
    step_src  = shamt;
    step_mode = i_alu_shift;
    if (state == ALU_EXEC_ST_SHIFT) begin
      step_val  = work;
      step_src  = rem;
      step_mode = mode_q;
    end
    step_amt = (step_src > STEP_AMT) ? STEP_AMT : step_src;
  end

  alu_shift_step #(
    .XLEN (XLEN)
  ) u_shift_step (
    .value   (step_val),
    .amount  (step_amt),
    .mode    (step_mode),
    .shifted (step_out)
  );

  always_comb begin
    func_result = '0;
    case (i_alu_ctl)
      ALU_CTL_ADD:      func_result = i_op_a + i_op_b;
      ALU_CTL_SUB:      func_result = i_op_a - i_op_b;
      ALU_CTL_LESS_SIG: func_result = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      ALU_CTL_LESS_UNS: func_result = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
      ALU_CTL_OR:       func_result = i_op_a | i_op_b;
      ALU_CTL_AND:      func_result = i_op_a & i_op_b;
      ALU_CTL_XOR:      func_result = i_op_a ^ i_op_b;
      ALU_CTL_SHIFT:    func_result = (i_alu_shift == ALU_SHIFT_NONE) ? i_op_a : step_out;
      default:          func_result = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ALU_EXEC_ST_IDLE;
      rem      <= '0;
      work     <= '0;
      mode_q   <= ALU_SHIFT_NONE;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_zero   <= 1'b1;
    end else begin
      o_valid <= 1'b0;
      if (i_flush) begin
        state <= ALU_EXEC_ST_IDLE;
        rem   <= '0;
      end else if (state == ALU_EXEC_ST_IDLE) begin
        if (accept) begin
          if (long_shift) begin
            work   <= step_out;
            rem    <= shamt - STEP_AMT;
            mode_q <= i_alu_shift;
            state  <= ALU_EXEC_ST_SHIFT;
          end else begin
            o_result <= func_result;
            o_zero   <= (func_result == '0);
            o_valid  <= 1'b1;
          end
        end
      end else begin
        work <= step_out;
        if (rem <= STEP_AMT) begin
          rem      <= '0;
          state    <= ALU_EXEC_ST_IDLE;
          o_result <= step_out;
          o_zero   <= (step_out == '0);
          o_valid  <= 1'b1;
        end else begin
          rem <= rem - STEP_AMT;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_exec.sv
// tb/tb_alu_serial_exec.sv - directed self-checking bench for alu_serial_exec
module tb_alu_serial_exec;

  localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_LTS = 3'd2, C_LTU = 3'd3;
  localparam logic [2:0] C_OR = 3'd4, C_AND = 3'd5, C_XOR = 3'd6, C_SHF = 3'd7;
  localparam logic [1:0] S_NONE = 2'b00, S_SLL = 2'b01, S_SRL = 2'b10, S_SRA = 2'b11;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        flush;
  logic [2:0]  alu_ctl;
  logic [1:0]  alu_shift;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ready;
  logic        valid_out;
  logic [31:0] result;
  logic        zero;

  int n_cmp;
  int n_err;

  alu_serial_exec #(
    .XLEN       (32),
    .SHIFT_STEP (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid_in),
    .i_flush     (flush),
    .i_alu_ctl   (alu_ctl),
    .i_alu_shift (alu_shift),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .o_ready     (ready),
    .o_valid     (valid_out),
    .o_result    (result),
    .o_zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] ctl, input logic [1:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    valid_in  = 1'b1;
    alu_ctl   = ctl;
    alu_shift = sh;
    op_a      = a;
    op_b      = b;
    tick();
    valid_in  = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp_res, input logic exp_zero);
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    valid_in  = 1'b0;
    flush     = 1'b0;
    alu_ctl   = C_ADD;
    alu_shift = S_NONE;
    op_a      = '0;
    op_b      = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);

    issue(C_ADD, S_NONE, 32'h7FFF_FFFF, 32'd1);
    check_out("add_wrap", 32'h8000_0000, 1'b0);
    tick();
    check("valid_pulse_one_cycle", {31'd0, valid_out}, 32'd0);

    issue(C_SUB, S_NONE, 32'd5, 32'd5);
    check_out("sub_zero", 32'd0, 1'b1);
    issue(C_LTS, S_NONE, 32'hFFFF_FFFF, 32'd1);
    check_out("less_sig", 32'd1, 1'b0);
    issue(C_LTU, S_NONE, 32'hFFFF_FFFF, 32'd1);
    check_out("less_uns", 32'd0, 1'b1);
    issue(C_AND, S_NONE, 32'hFFFF_0000, 32'h0F0F_0F0F);
    check_out("and", 32'h0F0F_0000, 1'b0);
    issue(C_SHF, S_NONE, 32'hDEAD_BEEF, 32'd7);
    check_out("shift_none", 32'hDEAD_BEEF, 1'b0);
    issue(C_SHF, S_SLL, 32'd1, 32'd4);
    check_out("sll4", 32'h0000_0010, 1'b0);
    issue(C_SHF, S_SRL, 32'h8000_0000, 32'd0);
    check_out("srl0", 32'h8000_0000, 1'b0);

    // Two-step SLL: shamt 5 -> o_valid at N+2
    issue(C_SHF, S_SLL, 32'd3, 32'd5);
    check("sll5_busy_ready", {31'd0, ready}, 32'd0);
    check("sll5_busy_valid", {31'd0, valid_out}, 32'd0);
    tick();
    check_out("sll5", 32'h0000_0060, 1'b0);

    // SRA shamt 31: busy N+1..N+7, done N+8; an op presented while busy is ignored
    issue(C_SHF, S_SRA, 32'h8000_0000, 32'd31);
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("sra_busy_ready_%0d", k), {31'd0, ready}, 32'd0);
      check($sformatf("sra_busy_valid_%0d", k), {31'd0, valid_out}, 32'd0);
      if (k == 2) begin
        valid_in = 1'b1;
        alu_ctl  = C_ADD;
        op_a     = 32'd100;
        op_b     = 32'd1;
      end
      if (k == 3) valid_in = 1'b0;
      tick();
    end
    check_out("sra31", 32'hFFFF_FFFF, 1'b0);
    check("sra31_ready", {31'd0, ready}, 32'd1);
    tick();
    check("busy_op_not_queued", {31'd0, valid_out}, 32'd0);

    // Flush mid-shift: SRL shamt 20 accepted at N, flush at N+2
    issue(C_SHF, S_SRL, 32'hF000_0000, 32'd20);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_valid", {31'd0, valid_out}, 32'd0);
    check("flush_result_held", result, 32'hFFFF_FFFF);
    issue(C_ADD, S_NONE, 32'd3, 32'd4);
    check_out("add_after_flush", 32'd7, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("flush_no_stale_valid_%0d", k), {31'd0, valid_out}, 32'd0);
    end

    // Flush and valid together: flush wins
    flush = 1'b1;
    issue(C_ADD, S_NONE, 32'd1, 32'd1);
    flush = 1'b0;
    check("flush_beats_valid", {31'd0, valid_out}, 32'd0);
    check("flush_beats_valid_res", result, 32'd7);

    // Back-to-back: OR accepted in the XOR's o_valid cycle
    issue(C_XOR, S_NONE, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check_out("xor", 32'h0FF0_0FF0, 1'b0);
    check("b2b_ready", {31'd0, ready}, 32'd1);
    issue(C_OR, S_NONE, 32'h1234_0000, 32'h0000_5678);
    check_out("or_b2b", 32'h1234_5678, 1'b0);
    tick();
    check("b2b_end", {31'd0, valid_out}, 32'd0);

    // Reset mid-shift returns outputs to reset values
    issue(C_SHF, S_SRA, 32'h8000_0000, 32'd31);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_ready", {31'd0, ready}, 32'd1);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_zero", {31'd0, zero}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rst_mid_no_valid_%0d", k), {31'd0, valid_out}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
